// File: rtl/sram22_ctrl_pkg.sv
// Shared widths and types for the 1024x32 SRAM controller (wmask granularity 8 bits).
package sram22_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 10;
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  typedef struct packed {
    logic                   we;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Small synchronous response FIFO; the head entry drives pop_data straight from storage.
module sram22_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage is reset as well so the head reads zero after a flush.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram22_1024x32m8w8_ctrl.sv
// Client-side controller for the 1024x32 byte-masked SRAM macro with optional zero-fill.
// Optional request counters are enabled by defining SRAM22_CTRL_STATS_EN.
module sram22_1024x32m8w8_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH     = 2,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   init_done,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM22_CTRL_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  rd_pend;
  logic                  started;
  logic                  accept;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  sram_req_t             pins;

  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;

  // Credits include the read in flight; a same-cycle pop frees its slot immediately.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_pend) - (CW+1)'(pop);
  assign req_ready = started && (state == RUN) && (occupancy < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;

  always_comb begin
    pins.we    = 1'b0;
    pins.wmask = '0;
    pins.addr  = last_addr;
    pins.wdata = '0;
    if (state == INIT) begin
      pins.we    = 1'b1;
      pins.wmask = '1;
      pins.addr  = init_cnt;
    end else if (accept) begin
      pins.we    = req_we;
      pins.wmask = req_wmask;
      pins.addr  = req_addr;
      pins.wdata = req_wdata;
    end
  end

  assign sram_we    = pins.we;
  assign sram_wmask = pins.wmask;
  assign sram_addr  = pins.addr;
  assign sram_din   = pins.wdata;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= INIT_ON_RESET ? INIT : RUN;
      init_cnt  <= '0;
      init_done <= ~INIT_ON_RESET;
      rd_pend   <= 1'b0;
      started   <= 1'b0;
      last_addr <= '0;
    end else begin
      started   <= 1'b1;
      rd_pend   <= accept & ~req_we;
      last_addr <= pins.addr;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (&init_cnt) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  // The macro's dout is only meaningful in the cycle after an accepted read.
  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (rd_pend),
    .push_data (sram_dout),
    .pop       (pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  no_push_when_full: assert property (@(posedge clk) disable iff (!rstb) !(rd_pend && fifo_full));

`ifdef SRAM22_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept) begin
      if (req_we) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram22_1024x32m8w8_ctrl.sv
// Bench for the SRAM controller: behavioural macro, array/queue reference model, scenario tasks.
module tb_sram22_1024x32m8w8_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
`ifdef SRAM22_CTRL_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mac_mem [NW];
  bit            mac_powered = 1'b0;
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_q [$];
  int            rd_acc;
  int            wr_acc;

  always #5 clk = ~clk;

  sram22_1024x32m8w8_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
`ifdef SRAM22_CTRL_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  // Macro model: powers up with garbage, commits masked writes at the edge, dout one cycle late.
  always @(posedge clk) begin
    if (!mac_powered) begin
      for (int i = 0; i < NW; i++) mac_mem[i] <= $urandom;
      mac_powered <= 1'b1;
      sram_dout   <= $urandom;
    end else if (sram_we) begin
      for (int b = 0; b < MW; b++)
        if (sram_wmask[b]) mac_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= $urandom;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (limit 1000000)");
    $fatal(1);
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    exp_q.delete();
    rd_acc = 0;
    wr_acc = 0;
  endtask

  // One clock: observe handshakes with the current inputs, advance the model, move to next negedge.
  task automatic tick(output bit acc, output bit pop, output logic [DW-1:0] got,
                      output logic [DW-1:0] want, output bit had);
    #1;
    acc  = req_valid && req_ready;
    pop  = rsp_valid && rsp_ready;
    got  = rsp_rdata;
    want = '0;
    had  = 1'b0;
    if (pop && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      had  = 1'b1;
    end
    if (acc) begin
      if (req_we) begin
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
        wr_acc++;
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
        rd_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_and_init(output bit ok);
    req_valid = 1'b0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    clear_model();
    ok = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (init_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    int bad_at;
    logic [AW-1:0] bad_addr;
    logic bad_we;
    bad_at = -1;
    bad_addr = '0;
    bad_we = 1'b0;
    rstb = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
    @(negedge clk);
    rstb = 1'b1;
    clear_model();
    for (int i = 0; i < NW; i++) begin
      #1;
      if (bad_at < 0 && (sram_we !== 1'b1 || sram_addr !== AW'(i) || sram_din !== '0 ||
                         sram_wmask !== 4'hF || req_ready !== 1'b0 || init_done !== 1'b0)) begin
        bad_at = i;
        bad_addr = sram_addr;
        bad_we = sram_we;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_at >= 0) begin
      errors++;
      $display("FAIL init_seq cycle %0d got we=%b addr=%0d want we=1 addr=%0d din=0 wmask=f ready=0",
               bad_at, bad_we, bad_addr, bad_at);
    end
    #1;
    checks++;
    if (sram_we !== 1'b0 || init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_end got we=%b done=%b ready=%b want we=0 done=1 ready=1",
               sram_we, init_done, req_ready);
    end
  endtask

  task automatic test_write_read();
    bit a, p, h;
    logic [DW-1:0] g, w;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5; req_wdata = 32'hDEADBEEF; req_wmask = 4'hF;
    tick(a, p, g, w, h);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", a); end
    req_we = 1'b0; req_wmask = '0; req_wdata = '0;
    tick(a, p, g, w, h);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_accept got %b want 1", a); end
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early rsp_valid got %b want 0", rsp_valid); end
    tick(a, p, g, w, h);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data got valid=%b data=%h want valid=1 data=deadbeef", rsp_valid, rsp_rdata);
    end
    tick(a, p, g, w, h);
    checks++;
    if (!(p && h && g === w)) begin
      errors++;
      $display("FAIL rd_pop got pop=%b data=%h want pop=1 data=%h", p, g, w);
    end
  endtask

  task automatic test_byte_mask();
    bit a, p, h, seen;
    logic [DW-1:0] g, w, got_data;
    seen = 1'b0;
    got_data = '0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7; req_wdata = 32'h11223344; req_wmask = 4'b0101;
    tick(a, p, g, w, h);
    req_we = 1'b0; req_wmask = '0; req_wdata = '0;
    tick(a, p, g, w, h);
    req_valid = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick(a, p, g, w, h);
      if (p) begin seen = 1'b1; got_data = g; end
    end
    checks++;
    if (!seen || got_data !== 32'h00220044) begin
      errors++;
      $display("FAIL byte_mask got seen=%b data=%h want seen=1 data=00220044", seen, got_data);
    end
  endtask

  task automatic test_backpressure();
    bit a1, a2, a, p, h;
    int late_acc;
    logic [DW-1:0] g, w;
    logic [DW-1:0] drained [$];
    late_acc = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_wmask = '0; req_addr = 10'd5;
    tick(a1, p, g, w, h);
    req_addr = 10'd7;
    tick(a2, p, g, w, h);
    req_addr = 10'd9;
    checks++; if (!(a1 && a2)) begin errors++; $display("FAIL bp_two_accepted got %b%b want 11", a1, a2); end
    repeat (3) begin
      tick(a, p, g, w, h);
      if (a) late_acc++;
    end
    checks++; if (late_acc != 0) begin errors++; $display("FAIL bp_third_stalled got %0d accepts want 0", late_acc); end
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_head_hold got valid=%b data=%h want valid=1 data=deadbeef", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick(a, p, g, w, h);
    checks++;
    if (!(a && p && g === 32'hDEADBEEF && g === w)) begin
      errors++;
      $display("FAIL bp_release got acc=%b pop=%b data=%h want acc=1 pop=1 data=deadbeef", a, p, g);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(a, p, g, w, h);
      if (p) begin
        drained.push_back(g);
        checks++;
        if (!h || g !== w) begin errors++; $display("FAIL bp_drain_model got %h want %h", g, w); end
      end
    end
    checks++;
    if (drained.size() != 2 || drained[0] !== 32'h00220044 || drained[1] !== 32'h0) begin
      errors++;
      $display("FAIL bp_drain_order got %0d responses (first %h) want 2: 00220044 00000000",
               drained.size(), (drained.size() > 0) ? drained[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    bit a, p, h, ok;
    int stalls, shown;
    logic [DW-1:0] g, w;
    stalls = 0;
    shown = 0;
    reset_and_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_init got init_done=%b want 1 within 1100 cycles", init_done); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_wmask = MW'($urandom_range(0, 15));
      tick(a, p, g, w, h);
      if (!a) stalls++;
      if (p) begin
        checks++;
        if (!h || g !== w) begin
          errors++;
          if (shown < 5) $display("FAIL rand_rsp req %0d got %h want %h", i, g, w);
          shown++;
        end
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(a, p, g, w, h);
      if (p) begin
        checks++;
        if (!h || g !== w) begin errors++; $display("FAIL rand_drain got %h want %h", g, w); end
      end
    end
    checks++; if (stalls != 0) begin errors++; $display("FAIL rand_no_stall got %0d stalls want 0", stalls); end
    checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_all_returned got %0d missing valid=%b want 0 missing valid=0", exp_q.size(), rsp_valid);
    end
`ifdef SRAM22_CTRL_STATS_EN
    checks++;
    if (rd_count !== 16'(rd_acc) || wr_count !== 16'(wr_acc) || (32'(rd_count) + 32'(wr_count)) != 1000) begin
      errors++;
      $display("FAIL rand_stats got rd=%0d wr=%0d want rd=%0d wr=%0d sum=1000", rd_count, wr_count, rd_acc, wr_acc);
    end
`endif
  endtask

  task automatic test_reset_midop();
    bit a, p, h, ok, seen;
    int bad_at;
    logic [DW-1:0] g, w, got_data;
    bad_at = -1;
    seen = 1'b0;
    got_data = '1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_wmask = '0; req_addr = 10'd5;
    tick(a, p, g, w, h);
    req_addr = 10'd6;
    tick(a, p, g, w, h);
    req_valid = 1'b0;
    tick(a, p, g, w, h);
    tick(a, p, g, w, h);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midop_queued got valid=%b want 1", rsp_valid); end
    rstb = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midop_flush got valid=%b data=%h ready=%b done=%b want 0 0 0 0",
               rsp_valid, rsp_rdata, req_ready, init_done);
    end
    @(negedge clk);
    rstb = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bad_at < 0 && (sram_we !== 1'b1 || sram_addr !== AW'(i) || sram_din !== '0)) bad_at = i;
      @(negedge clk);
    end
    checks++; if (bad_at >= 0) begin errors++; $display("FAIL midop_restart cycle %0d got addr=%0d want %0d", bad_at, sram_addr, bad_at); end
    ok = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (init_done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL midop_init_done got %b want 1", init_done); end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    tick(a, p, g, w, h);
    req_valid = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick(a, p, g, w, h);
      if (p) begin seen = 1'b1; got_data = g; end
    end
    checks++;
    if (!seen || got_data !== 32'h0) begin
      errors++;
      $display("FAIL midop_zeroed got seen=%b data=%h want seen=1 data=00000000", seen, got_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
